jtag_irx: RTL and testbench

Parametrised JTAG instruction register for the TAP: IR width, reset instruction and implemented-opcode set are configurable. Captures the 1149.1 `..01` pattern plus caller status bits, shifts LSB-first, and latches the new instruction on Update-IR. Unimplemented opcodes are forced to BYPASS. A registered one-hot decode and an update strobe drive the data-register muxing downstream of the TAP controller.

---
 rtl/jtag_irx.sv | 138 +++++++++++++
 tb/tb_jtag_irx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_irx.sv
`default_nettype none
// ============================================================================
// Module   : jtag_irx
// Purpose  : Parametrised JTAG instruction register. It captures the 1149.1
//            "..01" pattern together with caller status bits, shifts the
//            instruction LSB-first, and latches it on Update-IR. An
//            unimplemented opcode is replaced by BYPASS and raises a sticky
//            INVALID flag. A registered one-hot decode and an update strobe
//            feed the data-register muxing downstream of the TAP controller.
// Params   : IR_WIDTH    - instruction length (2..8)
//            RESET_INSTR - instruction loaded by TRST_N / TLR (must be
//                          implemented)
//            VALID_MASK  - bit i set => opcode i implemented (all-ones set)
// Ports    : TCK           in  TAP clock
//            TRST_N        in  asynchronous active-low reset
//            TDI           in  serial data in
//            TLR           in  Test-Logic-Reset state
//            CAPTUREIR     in  Capture-IR state
//            SHIFTIR       in  Shift-IR state
//            UPDATEIR      in  Update-IR state
//            STATUS        in  capture status (bits [1:0] ignored)
//            INSTR_TDO     out serial out, changes on negedge TCK
//            LATCH_JTAG_IR out active instruction
//            DECODE        out one-hot of LATCH_JTAG_IR, registered
//            UPDATE_STB    out one-TCK pulse after each Update-IR load
//            INVALID       out sticky unimplemented-opcode flag
// Revision : 1.0 - initial release
// ============================================================================
module jtag_irx #(
  parameter int unsigned                     IR_WIDTH    = 4,
  parameter logic [IR_WIDTH-1:0]             RESET_INSTR = IR_WIDTH'('h7),
  parameter logic [(1 << IR_WIDTH)-1:0]      VALID_MASK  = (1 << IR_WIDTH)'('h80C3)
) (
  input  logic                         TCK,
  input  logic                         TRST_N,
  input  logic                         TDI,
  input  logic                         TLR,
  input  logic                         CAPTUREIR,
  input  logic                         SHIFTIR,
  input  logic                         UPDATEIR,
  input  logic [IR_WIDTH-1:0]          STATUS,
  output logic                         INSTR_TDO,
  output logic [IR_WIDTH-1:0]          LATCH_JTAG_IR,
  output logic [(1 << IR_WIDTH)-1:0]   DECODE,
  output logic                         UPDATE_STB,
  output logic                         INVALID
);

  localparam int unsigned        DEC_W     = 1 << IR_WIDTH;
  localparam logic [IR_WIDTH-1:0] C_SR_RST = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] C_LOW2   = IR_WIDTH'(3);

  logic [IR_WIDTH-1:0] sr_q, sr_d;
  logic                tdo_q;
  logic [IR_WIDTH-1:0] latch_q, latch_d;
  logic [DEC_W-1:0]    dec_q, dec_d;
  logic                stb_q, stb_d;
  logic                inv_q, inv_d;
  logic [IR_WIDTH-1:0] w_cap_val;

  // Status bits above the fixed "01" pattern; masking (rather than slicing)
  // keeps the expression legal for IR_WIDTH = 2, where it collapses to 2'b01.
  assign w_cap_val = (STATUS & ~C_LOW2) | C_SR_RST;

  // --------------------------------------------------------------------------
  // Shift register: capture has priority over shift.
  // --------------------------------------------------------------------------
  always_comb begin
    sr_d = sr_q;
    if (CAPTUREIR) begin
      sr_d = w_cap_val;
    end else if (SHIFTIR) begin
      sr_d = {TDI, sr_q[IR_WIDTH-1:1]};
    end
  end

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      sr_q <= C_SR_RST;
    end else begin
      sr_q <= sr_d;
    end
  end

  // TDO is launched on the falling edge so it is stable for the next rising
  // edge at the receiving device.
  always_ff @(negedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      tdo_q <= 1'b0;
    end else begin
      tdo_q <= sr_q[0];
    end
  end

  // --------------------------------------------------------------------------
  // Latch path: TLR has priority over UPDATEIR. The update uses the shift
  // register contents present before this edge.
  // --------------------------------------------------------------------------
  always_comb begin
    latch_d = latch_q;
    inv_d   = inv_q;
    stb_d   = UPDATEIR & ~TLR;
    if (TLR) begin
      latch_d = RESET_INSTR;
      inv_d   = 1'b0;
    end else if (UPDATEIR) begin
      if (VALID_MASK[sr_q]) begin
        latch_d = sr_q;
      end else begin
        latch_d = '1;
        inv_d   = 1'b1;
      end
    end
    dec_d = DEC_W'(1) << latch_d;
  end

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      latch_q <= RESET_INSTR;
      dec_q   <= DEC_W'(1) << RESET_INSTR;
      stb_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      latch_q <= latch_d;
      dec_q   <= dec_d;
      stb_q   <= stb_d;
      inv_q   <= inv_d;
    end
  end

  assign INSTR_TDO     = tdo_q;
  assign LATCH_JTAG_IR = latch_q;
  assign DECODE        = dec_q;
  assign UPDATE_STB    = stb_q;
  assign INVALID       = inv_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_irx.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_irx
// Purpose  : Self-checking bench for jtag_irx. Two instances (IR_WIDTH=4 and
//            IR_WIDTH=2) share one set of TAP strobes. A behavioural model
//            pushes per-cycle state expectations and per-update results into
//            queues; a monitor pops and compares them at each falling edge.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_jtag_irx;

  logic       tck = 1'b0;
  logic       trst_n, tdi, tlr, cap, shf, upd;
  logic [3:0] status;

  always #5 tck = ~tck;

  logic        u4_tdo, u4_stb, u4_inv;
  logic [3:0]  u4_latch;
  logic [15:0] u4_dec;
  logic        u2_tdo, u2_stb, u2_inv;
  logic [1:0]  u2_latch;
  logic [3:0]  u2_dec;

  jtag_irx #(.IR_WIDTH(4), .RESET_INSTR(4'h7), .VALID_MASK(16'h80C3)) u4 (
    .TCK(tck), .TRST_N(trst_n), .TDI(tdi), .TLR(tlr), .CAPTUREIR(cap),
    .SHIFTIR(shf), .UPDATEIR(upd), .STATUS(status), .INSTR_TDO(u4_tdo),
    .LATCH_JTAG_IR(u4_latch), .DECODE(u4_dec), .UPDATE_STB(u4_stb),
    .INVALID(u4_inv)
  );

  jtag_irx #(.IR_WIDTH(2), .RESET_INSTR(2'h1), .VALID_MASK(4'b1010)) u2 (
    .TCK(tck), .TRST_N(trst_n), .TDI(tdi), .TLR(tlr), .CAPTUREIR(cap),
    .SHIFTIR(shf), .UPDATEIR(upd), .STATUS(status[1:0]), .INSTR_TDO(u2_tdo),
    .LATCH_JTAG_IR(u2_latch), .DECODE(u2_dec), .UPDATE_STB(u2_stb),
    .INVALID(u2_inv)
  );

  typedef struct packed {
    logic        tdo;
    logic [3:0]  latch;
    logic [15:0] dec;
    logic        stb;
    logic        inv;
  } snap_t;

  typedef struct packed {
    logic [3:0]  latch;
    logic [15:0] dec;
    logic        inv;
  } upd_t;

  snap_t cq4[$], cq2[$];
  upd_t  uq4[$], uq2[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain integers per instance (0 = width 4, 1 = width 2).
  int m_w[2]    = '{4, 2};
  int m_ri[2]   = '{7, 1};
  int m_mask[2] = '{32'h80C3, 32'h000A};
  int m_sr[2]   = '{1, 1};
  int m_latch[2] = '{7, 1};
  int m_inv[2]  = '{0, 0};

  task automatic model_step(input int k);
    int    full;
    int    old_sr;
    int    stb;
    snap_t s;
    upd_t  u;
    full   = (1 << m_w[k]) - 1;
    old_sr = m_sr[k];
    stb    = 0;
    s      = '0;
    if (!trst_n) begin
      m_sr[k]    = 1;
      m_latch[k] = m_ri[k];
      m_inv[k]   = 0;
      s.tdo      = 1'b0;
    end else begin
      if (tlr) begin
        m_latch[k] = m_ri[k];
        m_inv[k]   = 0;
      end else if (upd) begin
        if (((m_mask[k] >> old_sr) & 1) == 1) begin
          m_latch[k] = old_sr;
        end else begin
          m_latch[k] = full;
          m_inv[k]   = 1;
        end
      end
      stb = (upd && !tlr) ? 1 : 0;
      if (cap)      m_sr[k] = ((int'(status) & ~3) | 1) & full;
      else if (shf) m_sr[k] = (m_sr[k] >> 1) | (int'(tdi) << (m_w[k] - 1));
      s.tdo = m_sr[k][0];
    end
    s.latch = 4'(m_latch[k]);
    s.dec   = 16'(1 << m_latch[k]);
    s.stb   = stb[0];
    s.inv   = m_inv[k][0];
    u.latch = s.latch;
    u.dec   = s.dec;
    u.inv   = s.inv;
    if (k == 0) begin
      cq4.push_back(s);
      if (stb != 0) uq4.push_back(u);
    end else begin
      cq2.push_back(s);
      if (stb != 0) uq2.push_back(u);
    end
  endtask

  // Monitor: compares state once per cycle and update results on each strobe.
  task automatic check(input int k);
    snap_t a, e;
    upd_t  au, eu;
    logic  have_s, have_u;
    if (k == 0) a = {u4_tdo, u4_latch, u4_dec, u4_stb, u4_inv};
    else        a = {u2_tdo, 2'b00, u2_latch, 12'h000, u2_dec, u2_stb, u2_inv};
    have_s = (k == 0) ? (cq4.size() > 0) : (cq2.size() > 0);
    if (have_s) begin
      e = (k == 0) ? cq4.pop_front() : cq2.pop_front();
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL state w%0d t=%0t: got tdo=%b ir=%h dec=%h stb=%b inv=%b exp tdo=%b ir=%h dec=%h stb=%b inv=%b",
                 m_w[k], $time, a.tdo, a.latch, a.dec, a.stb, a.inv,
                 e.tdo, e.latch, e.dec, e.stb, e.inv);
      end
    end
    if (a.stb === 1'b1) begin
      au = {a.latch, a.dec, a.inv};
      have_u = (k == 0) ? (uq4.size() > 0) : (uq2.size() > 0);
      n_cmp++;
      if (!have_u) begin
        n_bad++;
        $display("FAIL update w%0d t=%0t: strobe with ir=%h but no update expected",
                 m_w[k], $time, au.latch);
      end else begin
        eu = (k == 0) ? uq4.pop_front() : uq2.pop_front();
        if (au !== eu) begin
          n_bad++;
          $display("FAIL update w%0d t=%0t: got ir=%h dec=%h inv=%b exp ir=%h dec=%h inv=%b",
                   m_w[k], $time, au.latch, au.dec, au.inv, eu.latch, eu.dec, eu.inv);
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge tck);
      #1;
      check(0);
      check(1);
    end
  end

  task automatic reset_check();
    n_cmp++;
    if ({u4_tdo, u4_latch, u4_dec, u4_stb, u4_inv} !== {1'b0, 4'h7, 16'h0080, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL async_reset w4: got tdo=%b ir=%h dec=%h stb=%b inv=%b exp 0 7 0080 0 0",
               u4_tdo, u4_latch, u4_dec, u4_stb, u4_inv);
    end
    n_cmp++;
    if ({u2_tdo, u2_latch, u2_dec, u2_stb, u2_inv} !== {1'b0, 2'h1, 4'h2, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL async_reset w2: got tdo=%b ir=%h dec=%h stb=%b inv=%b exp 0 1 2 0 0",
               u2_tdo, u2_latch, u2_dec, u2_stb, u2_inv);
    end
  endtask

  // One TCK cycle: drive after the falling edge, model after the rising edge.
  task automatic cyc(input logic r, input logic t, input logic c, input logic s,
                     input logic u, input logic d, input logic [3:0] st);
    logic fall;
    @(negedge tck);
    #2;
    fall   = trst_n & ~r;
    trst_n = r;
    tlr    = t;
    cap    = c;
    shf    = s;
    upd    = u;
    tdi    = d;
    status = st;
    if (fall) begin
      #1;
      reset_check();
    end
    @(posedge tck);
    #1;
    model_step(0);
    model_step(1);
  endtask

  task automatic shift4(input logic [3:0] op);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 0, op[i], 4'h0);
  endtask

  initial begin
    trst_n = 1'b0; tlr = 1'b0; cap = 1'b0; shf = 1'b0; upd = 1'b0;
    tdi = 1'b0; status = 4'h0;
    cyc(0, 0, 0, 0, 0, 0, 4'h0);
    cyc(0, 0, 0, 0, 0, 0, 4'h0);
    cyc(1, 0, 0, 0, 0, 0, 4'h0);
    // Capture STATUS=A then shift zeros
    cyc(1, 0, 1, 0, 0, 0, 4'hA);
    shift4(4'h0);
    // Valid, invalid, and subsequent valid updates
    shift4(4'h6); cyc(1, 0, 0, 0, 1, 0, 4'h0); cyc(1, 0, 0, 0, 0, 0, 4'h0);
    shift4(4'h3); cyc(1, 0, 0, 0, 1, 0, 4'h0); cyc(1, 0, 0, 0, 0, 0, 4'h0);
    shift4(4'h1); cyc(1, 0, 0, 0, 1, 0, 4'h0); cyc(1, 0, 0, 0, 0, 0, 4'h0);
    // TLR together with UPDATEIR, then held TLR
    cyc(1, 1, 0, 0, 1, 0, 4'h0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0, 4'h0);
    // Capture and shift together: capture wins
    cyc(1, 0, 1, 1, 0, 1, 4'h5);
    // Reset mid-shift
    cyc(1, 0, 0, 1, 0, 1, 4'h0);
    cyc(1, 0, 0, 1, 0, 1, 4'h0);
    cyc(0, 0, 0, 1, 0, 1, 4'h0);
    cyc(1, 0, 0, 0, 0, 0, 4'h0);
    // Width-2 flow: capture, shift opcode 0, update
    cyc(1, 0, 1, 0, 0, 0, 4'hC);
    cyc(1, 0, 0, 1, 0, 0, 4'h0);
    cyc(1, 0, 0, 1, 0, 0, 4'h0);
    cyc(1, 0, 0, 0, 1, 0, 4'h0);
    cyc(1, 0, 0, 0, 0, 0, 4'h0);
    // Randomized traffic, including overlapping strobes and resets
    for (int n = 0; n < 3000; n++) begin
      logic r, t, c, s, u, d;
      int   sel;
      r = ($urandom_range(0, 199) != 0);
      t = 1'b0; c = 1'b0; s = 1'b0; u = 1'b0;
      d = 1'($urandom);
      sel = int'($urandom_range(0, 11));
      case (sel)
        0:       t = 1'b1;
        1:       c = 1'b1;
        2, 3, 4, 5, 6: s = 1'b1;
        7, 8:    u = 1'b1;
        9:       begin t = 1'($urandom); c = 1'($urandom); s = 1'($urandom); u = 1'($urandom); end
        default: ;
      endcase
      cyc(r, t, c, s, u, d, 4'($urandom));
    end
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 4'h0);
    @(negedge tck);
    #3;
    n_cmp++;
    if ((cq4.size() + cq2.size() + uq4.size() + uq2.size()) != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d expectations left, exp 0",
               cq4.size() + cq2.size() + uq4.size() + uq2.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
